// File: rtl/wb_arbiter.sv
// Two-master Wishbone B4 arbiter: round-robin on simultaneous requests, ownership held for the whole CYC,
// and a watchdog that terminates a transfer the slave never acknowledges.
module wb_arbiter #(
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    // master 0 (load/store unit)
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,

    // master 1 (instruction fetch)
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,

    // shared slave bus
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [15:0] wdog_q, wdog_d;

    logic        own_stb;
    logic        wd_expire;

    // Selects depend only on the state, so an idle master's X inputs never reach the outputs.
    assign own_stb   = (state_q == GRANT0) ? m0_stb_i :
                       (state_q == GRANT1) ? m1_stb_i : 1'b0;
    assign wd_expire = own_stb && !s_ack_i && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            wdog_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            wdog_q       <= wdog_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_owner_q ? GRANT0 : GRANT1;
                end else if (m0_cyc_i) begin
                    state_d = GRANT0;
                end else if (m1_cyc_i) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_cyc_i) begin
                    state_d      = m1_cyc_i ? GRANT1 : IDLE;
                    last_owner_d = 1'b0;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    state_d      = m0_cyc_i ? GRANT0 : IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An expiry acts as the ACK of the stalled transfer, so the count restarts after it.
        wdog_d = wdog_q;
        if ((state_d != state_q) || !own_stb || s_ack_i || wd_expire) begin
            wdog_d = 16'd0;
        end else begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    always_comb begin
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        grant    = 2'b00;
        timeout  = wd_expire;
        case (state_q)
            GRANT0: begin
                grant    = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_stb_o  = m0_stb_i && !wd_expire;
                s_cyc_o  = m0_cyc_i && !wd_expire;
                m0_ack_o = s_ack_i || wd_expire;
                if (wd_expire) begin
                    m0_dat_o = TIMEOUT_DATA;
                end
            end
            GRANT1: begin
                grant    = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_stb_o  = m1_stb_i && !wd_expire;
                s_cyc_o  = m1_cyc_i && !wd_expire;
                m1_ack_o = s_ack_i || wd_expire;
                if (wd_expire) begin
                    m1_dat_o = TIMEOUT_DATA;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning slave cycles without ACK before the watchdog terminates a transfer (legal range 2..65535).
REQ-002 SHALL have parameter TIMEOUT_DATA, default 32'h00000000, meaning the read data returned to a master on watchdog termination.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port m0_bus  WB4 slave side  --  master 0, the data bus driven by the load/store unit.
REQ-007 SHALL have port m1_bus  WB4 slave side  --  master 1, the instruction-fetch bus.
REQ-008 SHALL have port s_bus  WB4 master side  --  shared bus to memory/peripherals (ADR, DAT_O, WE, STB, CYC out; DAT_I, ACK in).
REQ-009 SHALL have port grant  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse when the watchdog terminates a transfer.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT0, GRANT1 plus a last_owner register (0 = m0, 1 = m1).
REQ-012 In IDLE, SHALL move on the next edge: only m0.CYC high -> GRANT0; only m1.CYC high -> GRANT1; both high -> grant the master that is not last_owner (round-robin); neither -> stay IDLE.
REQ-013 Grant SHALL be registered: a request first seen in IDLE at cycle N reaches s_bus no earlier than cycle N+1.
REQ-014 In GRANTx, SHALL drive s_bus ADR, DAT_O, WE, STB and CYC combinationally from master x; in IDLE, SHALL drive all s_bus outputs to 0.
REQ-015 SHALL route s_bus.ACK only to the granted master; the non-granted master's ACK SHALL be 0.
REQ-016 SHALL drive s_bus.DAT_I to both masters' DAT_I in every state.
REQ-017 Ownership SHALL be held while master x keeps CYC high, including across STB-low gaps and multiple ACKed transfers.
REQ-018 In GRANTx, when x.CYC is low, SHALL on the next edge go to GRANTy if y.CYC is high, else to IDLE; last_owner SHALL be set to x.
REQ-019 SHALL never preempt a master whose CYC is high, whatever the other master is requesting.
REQ-020 Watchdog: a 16-bit counter SHALL increment each cycle in GRANTx with x.STB=1 and s_bus.ACK=0.
REQ-021 The watchdog counter SHALL clear on s_bus.ACK, on STB low, and on any state change.
REQ-022 When the counter equals TIMEOUT-1 with no ACK, SHALL for that one cycle assert ACK to master x, present TIMEOUT_DATA on x.DAT_I, force s_bus.STB and s_bus.CYC to 0, and pulse timeout.
REQ-023 If s_bus.ACK and watchdog expiry coincide in a cycle, SHALL give the real ACK and real data priority and SHALL NOT pulse timeout.
REQ-024 An ACK (real or watchdog) SHALL last exactly one cycle per transfer; the arbiter SHALL add no latency on the ACK or DAT_I path.
REQ-025 SHALL produce no X on any output when an idle master's inputs are X.

Reset
REQ-026 While rst=0, SHALL hold state IDLE, last_owner=1 (so m0 wins the first tie), watchdog counter=0, grant=00, timeout=0, all s_bus outputs=0, and both master ACKs=0.
REQ-027 Reset assertion mid-transfer SHALL abort immediately (asynchronously), with no ACK issued to either master.
REQ-028 After rst deasserts, arbitration SHALL resume from IDLE on the first rising edge.

Verification
REQ-029 Reset release, then m0 and m1 both raise CYC/STB in the same cycle -> grant=01 next cycle; m0 completes with slave ACK; m0 drops CYC -> grant=10 the following cycle, with no IDLE gap.
REQ-030 m1 holds CYC for 3 transfers while m0 requests continuously -> grant stays 10 for all 3; m0 granted only after m1.CYC falls; m0 sees ACK=0 throughout.
REQ-031 m0 write ADR=32'h0000_0104, DAT_O=32'hCAFEBABE, WE=1 -> s_bus mirrors the same values in the grant cycle; the slave ACK after 2 wait states reaches m0 only.
REQ-032 TIMEOUT=8, slave never ACKs m1 read -> m1 ACK=1 with DAT_I=TIMEOUT_DATA exactly 8 cycles after STB is first seen on s_bus; timeout pulses 1 cycle; s_bus.CYC=0 in that cycle.
REQ-033 Slave ACK arrives in the same cycle the watchdog would expire -> real DAT_I delivered, timeout stays 0.
REQ-034 rst pulled low mid-transfer while s_bus.STB=1 -> all outputs 0 immediately without waiting for a clock edge; after release, a pending m1 request is granted with grant=10 one cycle later.
